// File: rtl/lfsr_checker_if.sv
// -----------------------------------------------------------------------------
// lfsr_checker_if
// Bundle between a PRBS source and the lfsr_checker receive-side checker.
//
// Signals
//   i_valid          : i_lfsr carries a new word this cycle
//   i_lfsr [7:0]     : received LFSR word
//   i_clear_cnt      : synchronous clear of the error counter(s)
//   o_lock           : checker locked to the sequence
//   o_err            : one-cycle pulse, last valid word mismatched while locked
//   o_err_count      : saturating count of mismatched words while locked
//   o_bit_err_count  : saturating count of mismatched bits while locked
//                      (present only when LFSR_CHECKER_BITERR_EN is defined)
//
// Modports
//   master : the side that drives the stream and observes the status
//   slave  : the checker itself
// -----------------------------------------------------------------------------
interface lfsr_checker_if #(
  parameter int CNT_W = 16
);
  logic             i_valid;
  logic [7:0]       i_lfsr;
  logic             i_clear_cnt;
  logic             o_lock;
  logic             o_err;
  logic [CNT_W-1:0] o_err_count;
`ifdef LFSR_CHECKER_BITERR_EN
  logic [CNT_W-1:0] o_bit_err_count;

  modport master (
    output i_valid, i_lfsr, i_clear_cnt,
    input  o_lock, o_err, o_err_count, o_bit_err_count
  );

  modport slave (
    input  i_valid, i_lfsr, i_clear_cnt,
    output o_lock, o_err, o_err_count, o_bit_err_count
  );
`else
  modport master (
    output i_valid, i_lfsr, i_clear_cnt,
    input  o_lock, o_err, o_err_count
  );

  modport slave (
    input  i_valid, i_lfsr, i_clear_cnt,
    output o_lock, o_err, o_err_count
  );
`endif
endinterface

// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
// Receive-side checker for the 8-bit PRBS stream of the LFSR generator.
// It self-synchronises by watching for LOCK_COUNT consecutive correct
// successors, then runs its own copy of the sequence as a flywheel and
// counts every word (and optionally every bit) that disagrees with it.
// UNLOCK_COUNT consecutive mismatches drop it back to re-synchronisation.
//
// Parameters
//   LOCK_COUNT   : consecutive correct predictions needed to lock (1..255)
//   UNLOCK_COUNT : consecutive mismatches while locked that drop lock (1..255)
//   CNT_W        : width of the error counter(s); must match bus CNT_W
//
// Ports
//   clk     : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : lfsr_checker_if.slave (i_valid, i_lfsr, i_clear_cnt in;
//             o_lock, o_err, o_err_count [, o_bit_err_count] out)
//
// Optional feature
//   LFSR_CHECKER_BITERR_EN : when defined, adds o_bit_err_count, a saturating
//   count of mismatched bits while locked, cleared like o_err_count.
// -----------------------------------------------------------------------------
module lfsr_checker #(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int CNT_W        = 16
) (
  input  logic          clk,
  input  logic          i_rst_n,
  lfsr_checker_if.slave bus
);

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_SYNC,
    ST_LOCKED
  } state_t;

  localparam logic [7:0] LOCK_TGT   = 8'(LOCK_COUNT);
  localparam logic [7:0] UNLOCK_TGT = 8'(UNLOCK_COUNT);

  // Generator next-state function, written bit-for-bit like the source.
  function automatic logic [7:0] step(input logic [7:0] b);
    logic fb;
    fb   = b[7] ^ (b[6:0] == 7'd0);
    step = {b[6] ^ fb, b[5], b[4], b[3], b[2] ^ fb, b[1] ^ fb, b[0], fb};
  endfunction

  state_t           state_q, state_d;
  logic [7:0]       ref_q, ref_d;      // last word seen while synchronising
  logic [7:0]       exp_q, exp_d;      // flywheel prediction while locked
  logic [7:0]       match_q, match_d;
  logic [7:0]       miss_q, miss_d;
  logic [7:0]       match_inc, miss_inc;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef LFSR_CHECKER_BITERR_EN
  // Sum is wide enough for a full count plus up to 8 new bit errors.
  localparam int SUM_W = ((CNT_W > 4) ? CNT_W : 4) + 1;
  localparam logic [SUM_W-1:0] BIT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]       bit_diff;
  logic [SUM_W-1:0] bit_sum;
`endif

  // NOTE: every signal driven here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d   = state_q;
    ref_d     = ref_q;
    exp_d     = exp_q;
    match_d   = match_q;
    miss_d    = miss_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    match_inc = match_q + 8'd1;
    miss_inc  = miss_q + 8'd1;
`ifdef LFSR_CHECKER_BITERR_EN
    bit_cnt_d = bit_cnt_q;
    bit_diff  = 4'($countones(bus.i_lfsr ^ exp_q));
    bit_sum   = SUM_W'(bit_cnt_q) + SUM_W'(bit_diff);
`endif

    if (bus.i_valid) begin
      unique case (state_q)
        ST_UNLOCKED: begin
          ref_d   = bus.i_lfsr;
          match_d = '0;
          state_d = ST_SYNC;
        end

        ST_SYNC: begin
          ref_d = bus.i_lfsr;
          if (bus.i_lfsr == step(ref_q)) begin
            match_d = match_inc;
            if (match_inc == LOCK_TGT) begin
              state_d = ST_LOCKED;
              exp_d   = step(bus.i_lfsr);
              miss_d  = '0;
            end
          end else begin
            match_d = '0;
          end
        end

        ST_LOCKED: begin
          // The flywheel always advances; it never reloads from the input.
          exp_d = step(exp_q);
          if (bus.i_lfsr != exp_q) begin
            err_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
`ifdef LFSR_CHECKER_BITERR_EN
            bit_cnt_d = (bit_sum > BIT_MAX) ? '1 : CNT_W'(bit_sum);
`endif
            miss_d = miss_inc;
            if (miss_inc == UNLOCK_TGT) begin
              // The unlocking word is still counted, and it seeds re-sync.
              state_d = ST_SYNC;
              ref_d   = bus.i_lfsr;
              match_d = '0;
              miss_d  = '0;
            end
          end else begin
            miss_d = '0;
          end
        end

        default: state_d = ST_UNLOCKED;
      endcase
    end

    // Clear beats a same-cycle increment; o_err still pulses.
    if (bus.i_clear_cnt) begin
      cnt_d = '0;
`ifdef LFSR_CHECKER_BITERR_EN
      bit_cnt_d = '0;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_UNLOCKED;
      ref_q   <= '0;
      exp_q   <= '0;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef LFSR_CHECKER_BITERR_EN
      bit_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      exp_q   <= exp_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef LFSR_CHECKER_BITERR_EN
      bit_cnt_q <= bit_cnt_d;
`endif
    end
  end

  assign bus.o_lock      = (state_q == ST_LOCKED);
  assign bus.o_err       = err_q;
  assign bus.o_err_count = cnt_q;
`ifdef LFSR_CHECKER_BITERR_EN
  assign bus.o_bit_err_count = bit_cnt_q;
`endif

endmodule
